// File: rtl/bp_pkg.sv
// Shared types and counter constants for the branch target buffer.
// Entry fields are sized for the widest supported configuration; the top uses the low bits.
package bp_pkg;

   localparam int unsigned CTR_MAX  = 4;
   localparam int unsigned ADDR_MAX = 64;

   typedef logic [CTR_MAX-1:0] ctr_t;

   typedef struct packed {
      logic                valid;
      logic [ADDR_MAX-1:0] tag;
      logic [ADDR_MAX-1:0] target;
      ctr_t                ctr;
   } btb_entry_t;

   function automatic ctr_t weak_taken(int unsigned bits);
      return ctr_t'(1) << (bits - 1);
   endfunction

   function automatic ctr_t strong_taken(int unsigned bits);
      return (ctr_t'(1) << bits) - ctr_t'(1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter next-state logic for branch direction history.
module sat_counter #(
   parameter int unsigned CTR_BITS = 2
) (
   input  logic [CTR_BITS-1:0] cur,
   input  logic                taken,
   output logic [CTR_BITS-1:0] nxt
);

   always_comb begin
      nxt = cur;
      if (taken) begin
         if (cur != '1) nxt = cur + 1'b1;
      end else if (cur != '0) begin
         nxt = cur - 1'b1;
      end
   end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters,
// a zero-latency lookup port, one update port and saturating statistics.
module branch_predictor_btb
   import bp_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 32,
   parameter int unsigned CTR_BITS    = 2,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lkp_valid,
   input  logic [ADDR_W-1:0] lkp_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_pred_taken,
   input  logic [ADDR_W-1:0] upd_pred_target,
   output logic              mispredict,
   input  logic              flush_all,
   output logic [31:0]       stat_lookups,
   output logic [31:0]       stat_mispred
);

   localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
   localparam ctr_t        WEAK  = weak_taken(CTR_BITS);

   if (NUM_ENTRIES < 4 || (NUM_ENTRIES & (NUM_ENTRIES - 1)) != 0 || CTR_BITS < 1 ||
       CTR_BITS > CTR_MAX || ADDR_W > ADDR_MAX || ADDR_W < IDX_W + 3) begin : g_param_check
      $error("branch_predictor_btb: unsupported parameter combination");
   end

   btb_entry_t mem [NUM_ENTRIES];

   logic [IDX_W-1:0]    lkp_idx, upd_idx;
   logic [ADDR_MAX-1:0] lkp_tag, upd_tag;
   btb_entry_t          lkp_ent, upd_ent, wr_ent;
   logic                upd_hit, upd_we, mispred_d;
   logic [CTR_BITS-1:0] ctr_nxt;
   logic                mispredict_q;
   logic [31:0]         stat_lookups_q, stat_mispred_q;
   logic                unused_bits;

   assign lkp_idx = lkp_pc[IDX_W+1:2];
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign lkp_tag = ADDR_MAX'(lkp_pc[ADDR_W-1:IDX_W+2]);
   assign upd_tag = ADDR_MAX'(upd_pc[ADDR_W-1:IDX_W+2]);

   // Array reads see the pre-edge contents, which gives read-old on index collisions.
   assign lkp_ent     = mem[lkp_idx];
   assign pred_hit    = lkp_valid && lkp_ent.valid && (lkp_ent.tag == lkp_tag);
   assign pred_taken  = pred_hit && lkp_ent.ctr[CTR_BITS-1];
   assign pred_target = pred_hit ? lkp_ent.target[ADDR_W-1:0] : '0;

   assign upd_ent = mem[upd_idx];
   assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

   sat_counter #(
      .CTR_BITS(CTR_BITS)
   ) u_sat_counter (
      .cur  (upd_ent.ctr[CTR_BITS-1:0]),
      .taken(upd_taken),
      .nxt  (ctr_nxt)
   );

   always_comb begin
      wr_ent = upd_ent;
      upd_we = 1'b0;
      if (upd_valid) begin
         if (upd_hit) begin
            upd_we     = 1'b1;
            wr_ent.ctr = ctr_t'(ctr_nxt);
            if (upd_taken) wr_ent.target = ADDR_MAX'(upd_target);
         end else if (upd_taken) begin
            upd_we        = 1'b1;
            wr_ent.valid  = 1'b1;
            wr_ent.tag    = upd_tag;
            wr_ent.target = ADDR_MAX'(upd_target);
            wr_ent.ctr    = WEAK;
         end
      end
   end

   assign mispred_d = upd_valid && ((upd_taken != upd_pred_taken) ||
                                    (upd_taken && (upd_target != upd_pred_target)));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_ENTRIES; i++) mem[i[IDX_W-1:0]].valid <= 1'b0;
         mispredict_q   <= 1'b0;
         stat_lookups_q <= '0;
         stat_mispred_q <= '0;
      end else begin
         mispredict_q <= mispred_d;
         if (lkp_valid && stat_lookups_q != '1) stat_lookups_q <= stat_lookups_q + 32'd1;
         if (mispredict_q && stat_mispred_q != '1) stat_mispred_q <= stat_mispred_q + 32'd1;
         // Flush wins over a same-cycle update; the update's mispredict is still recorded above.
         if (flush_all) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) mem[i[IDX_W-1:0]].valid <= 1'b0;
         end else if (upd_we) begin
            mem[upd_idx] <= wr_ent;
         end
      end
   end

   assign mispredict   = mispredict_q;
   assign stat_lookups = stat_lookups_q;
   assign stat_mispred = stat_mispred_q;

   assign unused_bits = ^{lkp_ent, upd_ent, lkp_pc[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed vector table, a statistics saturation sequence,
// and randomized traffic checked against an array-based reference model.
module tb_branch_predictor_btb;

   localparam int unsigned N  = 32;
   localparam int unsigned CB = 2;
   localparam int unsigned IW = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        lkp_valid, upd_valid, upd_taken, upd_pred_taken, flush_all;
   logic [31:0] lkp_pc, upd_pc, upd_target, upd_pred_target;
   logic        pred_hit, pred_taken, mispredict;
   logic [31:0] pred_target, stat_lookups, stat_mispred;

   always #5 clk = ~clk;

   branch_predictor_btb #(
      .NUM_ENTRIES(N),
      .CTR_BITS   (CB),
      .ADDR_W     (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .lkp_valid      (lkp_valid),
      .lkp_pc         (lkp_pc),
      .pred_hit       (pred_hit),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_pred_taken (upd_pred_taken),
      .upd_pred_target(upd_pred_target),
      .mispredict     (mispredict),
      .flush_all      (flush_all),
      .stat_lookups   (stat_lookups),
      .stat_mispred   (stat_mispred)
   );

   typedef struct {
      bit          lv;
      logic [31:0] lpc;
      bit          uv;
      logic [31:0] upc;
      bit          ut;
      logic [31:0] utgt;
      bit          upt;
      logic [31:0] uptgt;
      bit          fl;
      bit          eh;
      bit          et;
      logic [31:0] etgt;
      bit          emis;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one slot per index holding the full upper-PC tag and a plain integer counter.
   bit          m_valid [N];
   logic [31:0] m_tag   [N];
   logic [31:0] m_tgt   [N];
   int          m_ctr   [N];
   bit          m_mis;
   logic [31:0] m_lkps, m_mstat;

   vec_t tbl[$];

   function automatic vec_t mk(bit lv, logic [31:0] lpc, bit uv, logic [31:0] upc, bit ut,
                               logic [31:0] utgt, bit upt, logic [31:0] uptgt, bit fl,
                               bit eh, bit et, logic [31:0] etgt, bit emis);
      vec_t v;
      v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
      v.upt = upt; v.uptgt = uptgt; v.fl = fl; v.eh = eh; v.et = et; v.etgt = etgt;
      v.emis = emis;
      return v;
   endfunction

   function automatic vec_t look(logic [31:0] pc, bit eh, bit et, logic [31:0] etgt);
      return mk(1, pc, 0, 0, 0, 0, 0, 0, 0, eh, et, etgt, 0);
   endfunction

   function automatic int idx_of(logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic logic [31:0] tag_of(logic [31:0] pc);
      return pc >> (IW + 2);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_update(bit r, vec_t v);
      int  i;
      int  cmax;
      bit  hit;
      if (r) begin
         for (int k = 0; k < N; k++) m_valid[k] = 0;
         m_mis = 0; m_lkps = 0; m_mstat = 0;
         return;
      end
      cmax = (1 << CB) - 1;
      if (m_mis && m_mstat != 32'hFFFF_FFFF) m_mstat++;
      if (v.lv && m_lkps != 32'hFFFF_FFFF) m_lkps++;
      m_mis = v.uv && ((v.ut != v.upt) || (v.ut && v.utgt != v.uptgt));
      if (v.fl) begin
         for (int k = 0; k < N; k++) m_valid[k] = 0;
      end else if (v.uv) begin
         i   = idx_of(v.upc);
         hit = m_valid[i] && m_tag[i] == tag_of(v.upc);
         if (hit) begin
            m_ctr[i] = v.ut ? ((m_ctr[i] < cmax) ? m_ctr[i] + 1 : cmax)
                            : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (v.ut) m_tgt[i] = v.utgt;
         end else if (v.ut) begin
            m_valid[i] = 1; m_tag[i] = tag_of(v.upc); m_tgt[i] = v.utgt;
            m_ctr[i] = 1 << (CB - 1);
         end
      end
   endtask

   // Starts one time unit after a rising edge and ends one time unit after the next.
   task automatic step(string name, bit r, vec_t v, bit use_exp);
      int          i;
      bit          eh, et;
      logic [31:0] etg;
      rst = r; lkp_valid = v.lv; lkp_pc = v.lpc; upd_valid = v.uv; upd_pc = v.upc;
      upd_taken = v.ut; upd_target = v.utgt; upd_pred_taken = v.upt;
      upd_pred_target = v.uptgt; flush_all = v.fl;
      #4;
      i   = idx_of(v.lpc);
      eh  = v.lv && m_valid[i] && m_tag[i] == tag_of(v.lpc);
      et  = eh && (m_ctr[i] >= (1 << (CB - 1)));
      etg = eh ? m_tgt[i] : 32'h0;
      check({name, " model hit"}, 32'(pred_hit), 32'(eh));
      check({name, " model taken"}, 32'(pred_taken), 32'(et));
      check({name, " model target"}, pred_target, etg);
      if (use_exp) begin
         check({name, " hit"}, 32'(pred_hit), 32'(v.eh));
         check({name, " taken"}, 32'(pred_taken), 32'(v.et));
         check({name, " target"}, pred_target, v.etgt);
      end
      model_update(r, v);
      @(posedge clk);
      #1;
      check({name, " model mispredict"}, 32'(mispredict), 32'(m_mis));
      check({name, " stat_lookups"}, stat_lookups, m_lkps);
      check({name, " stat_mispred"}, stat_mispred, m_mstat);
      if (use_exp) check({name, " mispredict"}, 32'(mispredict), 32'(v.emis));
   endtask

   function automatic logic [31:0] rnd_pc();
      logic [31:0] tp [4] = '{32'h0, 32'h1, 32'h3, 32'h1ABCD};
      return (tp[$urandom_range(0, 3)] << 7) | (32'($urandom_range(0, 7)) << 2) |
             32'($urandom_range(0, 3));
   endfunction

   initial begin
      vec_t v;
      rst = 1; lkp_valid = 0; lkp_pc = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
      upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0; flush_all = 0;
      repeat (3) @(posedge clk);
      #1;
      // Reset overrides a concurrent update and flush; lookups read zero.
      step("reset", 1, mk(1, 'h100, 1, 'h100, 1, 'h200, 0, 0, 1, 0, 0, 0, 0), 1);

      tbl.push_back(look('h100, 0, 0, 0));
      tbl.push_back(mk(1, 'h100, 1, 'h100, 1, 'h200, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(look('h100, 1, 1, 'h200));
      tbl.push_back(mk(1, 'h100, 1, 'h100, 0, 0, 1, 'h200, 0, 1, 1, 'h200, 1));
      tbl.push_back(mk(1, 'h100, 1, 'h100, 0, 0, 0, 0, 0, 1, 0, 'h200, 0));
      tbl.push_back(mk(1, 'h100, 1, 'h100, 0, 0, 0, 0, 0, 1, 0, 'h200, 0));
      tbl.push_back(look('h100, 1, 0, 'h200));
      tbl.push_back(mk(1, 'h100, 1, 'h100, 1, 'h200, 1, 'h200, 0, 1, 0, 'h200, 0));
      tbl.push_back(mk(1, 'h100, 1, 'h100, 1, 'h200, 1, 'h200, 0, 1, 0, 'h200, 0));
      tbl.push_back(mk(1, 'h100, 1, 'h100, 1, 'h200, 1, 'h200, 0, 1, 1, 'h200, 0));
      tbl.push_back(mk(1, 'h100, 1, 'h100, 1, 'h200, 1, 'h200, 0, 1, 1, 'h200, 0));
      tbl.push_back(mk(1, 'h100, 1, 'h100, 1, 'h200, 1, 'h200, 0, 1, 1, 'h200, 0));
      tbl.push_back(look('h100, 1, 1, 'h200));
      tbl.push_back(mk(1, 'h100, 1, 'h100, 0, 0, 0, 0, 0, 1, 1, 'h200, 0));
      tbl.push_back(look('h100, 1, 1, 'h200));
      tbl.push_back(mk(1, 'h100, 1, 'h100, 1, 'h300, 1, 'h200, 0, 1, 1, 'h200, 1));
      tbl.push_back(look('h100, 1, 1, 'h300));
      tbl.push_back(mk(1, 'h100, 1, 'h180, 1, 'h400, 0, 0, 0, 1, 1, 'h300, 1));
      tbl.push_back(look('h100, 0, 0, 0));
      tbl.push_back(look('h180, 1, 1, 'h400));
      tbl.push_back(look('h183, 1, 1, 'h400));
      tbl.push_back(mk(1, 'h14, 1, 'h14, 1, 'h500, 1, 'h500, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 'h14, 1, 'h14, 0, 0, 1, 'h500, 0, 1, 1, 'h500, 1));
      tbl.push_back(look('h14, 1, 0, 'h500));
      tbl.push_back(mk(0, 0, 1, 'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(look('h40, 0, 0, 0));
      tbl.push_back(mk(1, 'h14, 1, 'h20, 1, 'h600, 0, 0, 1, 1, 0, 'h500, 1));
      tbl.push_back(look('h20, 0, 0, 0));
      tbl.push_back(look('h180, 0, 0, 0));
      tbl.push_back(look('h14, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 'h180, 1, 'h400, 1, 'h400, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 'h180, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(look('h180, 1, 1, 'h400));

      foreach (tbl[k]) step($sformatf("row%0d", k), 0, tbl[k], 1);

      // Statistics saturation: preload the mispredict counter at its ceiling.
      force dut.stat_mispred_q = 32'hFFFF_FFFF;
      #1;
      release dut.stat_mispred_q;
      m_mstat = 32'hFFFF_FFFF;
      check("stat preload", stat_mispred, 32'hFFFF_FFFF);
      step("sat_mis", 0, mk(1, 'h180, 1, 'h180, 0, 0, 1, 'h400, 0, 1, 1, 'h400, 1), 1);
      step("sat_after", 0, look('h180, 1, 0, 'h400), 1);
      check("stat saturated", stat_mispred, 32'hFFFF_FFFF);

      for (int k = 0; k < 400; k++) begin
         v.lv    = ($urandom_range(0, 3) != 0);
         v.lpc   = rnd_pc();
         v.uv    = ($urandom_range(0, 1) != 0);
         v.upc   = ($urandom_range(0, 3) == 0) ? v.lpc : rnd_pc();
         v.ut    = ($urandom_range(0, 1) != 0);
         v.utgt  = 32'($urandom_range(1, 4)) << 8;
         v.upt   = ($urandom_range(0, 1) != 0);
         v.uptgt = ($urandom_range(0, 2) != 0) ? v.utgt : 32'($urandom_range(1, 4)) << 8;
         v.fl    = ($urandom_range(0, 39) == 0);
         step($sformatf("rnd%0d", k), ($urandom_range(0, 99) == 0), v, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_predictor_btb.md
BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

Interface
REQ-001 Parameter NUM_ENTRIES, default 32, number of BTB entries; SHALL be a power of two, at least 4.
REQ-002 Parameter CTR_BITS, default 2, saturating-counter width; SHALL be in the range 1 to 4.
REQ-003 Parameter ADDR_W, default 32, PC and target width.
REQ-004 Derived constants: IDX_W = log2(NUM_ENTRIES); TAG_W = ADDR_W-IDX_W-2.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  reset
REQ-006 Lookup (fetch-stage) ports:
- lkp_valid  in  1  lookup request
- lkp_pc  in  ADDR_W  fetch PC
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  predicted direction
- pred_target  out  ADDR_W  predicted target
REQ-007 Update (execute-stage) ports:
- upd_valid  in  1  resolved branch
- upd_pc  in  ADDR_W  branch PC
- upd_taken  in  1  actual direction
- upd_target  in  ADDR_W  actual target
- upd_pred_taken  in  1  prediction made at fetch
- upd_pred_target  in  ADDR_W  target predicted at fetch
- mispredict  out  1  registered mispredict flag
REQ-008 Control and statistics ports:
- flush_all  in  1  invalidate all entries
- stat_lookups  out  32  lookup count
- stat_mispred  out  32  mispredict count

Function
REQ-009 Each entry SHALL hold valid (1 bit), tag (TAG_W), target (ADDR_W) and counter (CTR_BITS).
REQ-010 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[ADDR_W-1:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-011 Lookup SHALL be combinational (zero latency): pred_hit = lkp_valid and valid and tag match; pred_taken = pred_hit and counter MSB; pred_target = entry target when pred_hit, else 0.
REQ-012 On an update hit (valid entry with matching tag) with upd_valid, the counter SHALL increment on taken and decrement on not-taken, saturating at all-ones and at 0; when upd_taken is set, target SHALL be overwritten with upd_target.
REQ-013 On an update miss with upd_taken=1, the block SHALL allocate the entry: valid=1, tag and target written, counter = weakly-taken (MSB set, other bits 0), replacing any previous occupant.
REQ-014 On an update miss with upd_taken=0, the block SHALL write nothing.
REQ-015 mispredict SHALL be asserted one cycle after an upd_valid cycle when upd_taken != upd_pred_taken, or when upd_taken and upd_target != upd_pred_target; otherwise 0.
REQ-016 When lookup and update hit the same index in the same cycle, lookup SHALL return pre-update contents (read-old); the update SHALL be visible from the next cycle.
REQ-017 flush_all SHALL clear every valid bit in one cycle; tags, targets and counters are don't-care.
REQ-018 flush_all SHALL take priority over an update in the same cycle, so that update is discarded.
REQ-019 mispredict and the statistics SHALL still be computed for an update discarded by flush_all.
REQ-020 stat_lookups SHALL increment on each lkp_valid cycle; stat_mispred SHALL increment on each mispredict assertion.
REQ-021 Both statistics counters SHALL saturate at 32'hFFFFFFFF and SHALL NOT wrap.

Reset
REQ-022 While rst=1 at a clk edge: all valid bits = 0, mispredict = 0, stat_lookups = 0, stat_mispred = 0; updates are ignored.
REQ-023 rst SHALL override flush_all and upd_valid.
REQ-024 Entry contents other than valid SHALL NOT require reset.
REQ-025 During rst, pred_hit, pred_taken and pred_target SHALL read 0, since all valid bits are cleared.

Structure
REQ-026 Package bp_pkg SHALL hold the counter-state typedef, a btb_entry_t struct typedef, and the weakly-taken/strongly-taken constants parameterised by CTR_BITS.
REQ-027 Saturating up/down counter next-state logic SHALL be a sub-module sat_counter (parameter CTR_BITS; inputs cur and taken; output nxt).
REQ-028 The entry array SHALL be a single register array with one write port and one read port.

Verification
REQ-029 Reset, then lookup at PC 0x100 -> pred_hit=0, pred_taken=0, pred_target=0.
REQ-030 Update at PC 0x100, taken, target 0x200, predicted not-taken; the next cycle, lookup 0x100 -> mispredict=1 in that cycle; pred_hit=1, pred_taken=1, pred_target=0x200.
REQ-031 Default parameters, three not-taken updates at a hit entry -> counter goes 10, 01, 00 and pred_taken=0; five taken updates -> counter saturates at 11.
REQ-032 Aliasing test: allocate PC 0x100, then a taken update at 0x180 (same index, NUM_ENTRIES=32) -> lookup 0x100 gives pred_hit=0; lookup 0x180 gives pred_hit=1.
REQ-033 Same-cycle lookup and update at index 5 -> lookup shows the old counter; the next cycle shows the new counter.
REQ-034 flush_all together with a taken update -> all lookups miss afterwards and mispredict is still produced; force stat_mispred to 0xFFFFFFFF, then mispredict -> value stays 0xFFFFFFFF.
